// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and the exercise environment.
//   master : checker side. Drives vec and the result signals; receives start
//            and the two DUT responses.
//   slave  : environment side. Drives start, dut_a and dut_b; observes the
//            vector and the results.
// Signals:
//   start        one-cycle pulse that begins a sweep
//   vec          current stimulus vector (MSB = first DUT input)
//   dut_a/dut_b  responses of the gate-level and expression-level DUTs
//   busy/done    sweep in progress / one-cycle completion pulse
//   pass         zero failing minterms (valid from done onward)
//   err_cnt      number of failing minterms
//   mismatch_map bit m set if minterm m failed
//   first_err    lowest failing minterm, 0 if none
interface truth_table_checker_if #(
    parameter int N_IN = 2
) ();
    logic                   start;
    logic [N_IN-1:0]        vec;
    logic                   dut_a;
    logic                   dut_b;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN+1:0]        err_cnt;
    logic [(1<<N_IN)-1:0]   mismatch_map;
    logic [N_IN-1:0]        first_err;

    modport master (
        input  start, dut_a, dut_b,
        output vec, busy, done, pass, err_cnt, mismatch_map, first_err
    );

    modport slave (
        output start, dut_a, dut_b,
        input  vec, busy, done, pass, err_cnt, mismatch_map, first_err
    );
endinterface

// File: rtl/truth_table_checker.sv
// Response analyzer for small combinational gate exercises. Sweeps every
// input vector in ascending minterm order, waits SETTLE+1 cycles after each
// vector change, then compares both DUT responses against the golden table
// and against each other, accumulating mismatch statistics.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   truth_table_checker_if.master (start, vec, dut_a/b, busy, done,
//         pass, err_cnt, mismatch_map, first_err)
module truth_table_checker #(
    parameter int                   N_IN      = 2,
    parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 4'b1101,
    parameter int                   SETTLE    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_checker_if.master  bus
);
    localparam int                NV          = 1 << N_IN;
    localparam logic [N_IN-1:0]   VEC_LAST    = '1;
    localparam logic [N_IN+1:0]   ERR_MAX     = (N_IN+2)'(NV);
    localparam logic [2:0]        SETTLE_LOAD = 3'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [N_IN+1:0]    err_q, err_d;
    logic [NV-1:0]      map_q, map_d;
    logic [N_IN-1:0]    first_q, first_d;
    logic               pass_q, pass_d;
    logic               exp_bit;
    logic               fail;

    // Case-inequality so X/Z responses count as failures in simulation.
    assign exp_bit = EXP_TABLE[vec_q];
    assign fail    = (bus.dut_a !== exp_bit) || (bus.dut_b !== exp_bit) ||
                     (bus.dut_a !== bus.dut_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            map_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            map_q   <= map_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == '0) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (vec_q == VEC_LAST) ? ST_FINISH : ST_DRIVE;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        map_d   = map_q;
        first_d = first_q;
        pass_d  = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    vec_d   = '0;
                    err_d   = '0;
                    map_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE:  cnt_d = SETTLE_LOAD;
            ST_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - 3'd1;
            ST_SAMPLE: begin
                if (fail) begin
                    map_d[vec_q] = 1'b1;
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (err_q == '0) first_d = vec_q;
                end
                // pass is resolved here so it already reflects the last
                // sample when done is shown in the following cycle.
                if (vec_q == VEC_LAST) begin
                    vec_d  = '0;
                    pass_d = (err_q == '0) && !fail;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                           (state_q == ST_SAMPLE);
        bus.done         = (state_q == ST_FINISH);
        bus.vec          = vec_q;
        bus.err_cnt      = err_q;
        bus.mismatch_map = map_q;
        bus.first_err    = first_q;
        bus.pass         = pass_q;
    end
endmodule
